mainfsm: RTL and testbench

MAINFSM -- requirements
Module: mainfsm

---
 rtl/mainfsm_pkg.sv | 53 +++++
 rtl/mainfsm_outdec.sv | 68 ++++++
 rtl/mainfsm.sv | 85 ++++++++
 tb/tb_mainfsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle processor main controller:
// state encodings, datapath select codes and the packed control word.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] OP_DP       = 2'b00;
    localparam logic [1:0] OP_MEM      = 2'b01;
    localparam logic [1:0] OP_BR       = 2'b10;
    localparam logic [1:0] OP_UNDEF    = 2'b11;

    localparam int FUNCT_I_BIT = 5;
    localparam int FUNCT_L_BIT = 0;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Moore output decoder: maps the current controller state to the control word.
// Unused encodings decode to an all-zero (inactive) control word.
module mainfsm_outdec
    import mainfsm_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write   = 1'b1;
                o_ctrl.next_pc    = 1'b1;
                o_ctrl.adr_src    = 1'b0;
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.result_src = RES_ALU;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.result_src = RES_ALU;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a  = SRCA_REG;
                o_ctrl.alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.result_src = RES_DATA;
                o_ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                o_ctrl.alu_src_b  = SRCB_REG;
                o_ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                o_ctrl.result_src = RES_ALUOUT;
                o_ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a  = SRCA_ALUOUT;
                o_ctrl.alu_src_b  = SRCB_IMM;
                o_ctrl.result_src = RES_ALU;
                o_ctrl.branch     = 1'b1;
            end
            S_UNKNOWN: begin
                o_ctrl.illegal    = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Main controller of a multicycle processor: state register and next-state
// logic here, state-to-output table in mainfsm_outdec.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State,
    output logic       Illegal
);

    state_t r_state;
    state_t w_state_next;
    ctrl_t  w_ctrl;
    logic   w_unused_funct;

    // Only the immediate and load flags steer the sequence.
    assign w_unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_UNKNOWN;
        case (r_state)
            S_FETCH:    w_state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:   w_state_next = S_MEMADR;
                    OP_DP:    w_state_next = Funct[FUNCT_I_BIT] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:    w_state_next = S_BRANCH;
                    OP_UNDEF: w_state_next = S_UNKNOWN;
                    default:  w_state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   w_state_next = Funct[FUNCT_L_BIT] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_state_next = S_MEMWB;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWR:    w_state_next = S_FETCH;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BRANCH:   w_state_next = S_FETCH;
            // UNKNOWN is absorbing; stray encodings also fall into it.
            S_UNKNOWN:  w_state_next = S_UNKNOWN;
            default:    w_state_next = S_UNKNOWN;
        endcase
    end

    mainfsm_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign IRWrite   = w_ctrl.ir_write;
    assign AdrSrc    = w_ctrl.adr_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ResultSrc = w_ctrl.result_src;
    assign NextPC    = w_ctrl.next_pc;
    assign RegW      = w_ctrl.reg_w;
    assign MemW      = w_ctrl.mem_w;
    assign Branch    = w_ctrl.branch;
    assign ALUOp     = w_ctrl.alu_op;
    assign Illegal   = w_ctrl.illegal;
    assign State     = r_state;

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: table of instructions with expected state
// walks, a per-cycle scoreboard of {state, outputs}, and reset corner cases.
module tb_mainfsm;

    localparam logic [3:0] ST_F   = 4'd0;
    localparam logic [3:0] ST_D   = 4'd1;
    localparam logic [3:0] ST_MA  = 4'd2;
    localparam logic [3:0] ST_MR  = 4'd3;
    localparam logic [3:0] ST_MWB = 4'd4;
    localparam logic [3:0] ST_MW  = 4'd5;
    localparam logic [3:0] ST_ER  = 4'd6;
    localparam logic [3:0] ST_EI  = 4'd7;
    localparam logic [3:0] ST_AW  = 4'd8;
    localparam logic [3:0] ST_BR  = 4'd9;
    localparam logic [3:0] ST_UNK = 4'd10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op    = 2'b00;
    logic [5:0] Funct = 6'b000000;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .State     (State),
        .Illegal   (Illegal)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal}
    logic [13:0] w_outs;
    assign w_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     NextPC, RegW, MemW, Branch, ALUOp, Illegal};

    function automatic logic [13:0] model_out(input logic [3:0] s);
        case (s)
            ST_F:    return 14'b1_0_01_10_10_1_0_0_0_0_0;
            ST_D:    return 14'b0_0_01_10_10_0_0_0_0_0_0;
            ST_MA:   return 14'b0_0_00_01_00_0_0_0_0_0_0;
            ST_MR:   return 14'b0_1_00_00_00_0_0_0_0_0_0;
            ST_MWB:  return 14'b0_0_00_00_01_0_1_0_0_0_0;
            ST_MW:   return 14'b0_1_00_00_00_0_0_1_0_0_0;
            ST_ER:   return 14'b0_0_00_00_00_0_0_0_0_1_0;
            ST_EI:   return 14'b0_0_00_01_00_0_0_0_0_1_0;
            ST_AW:   return 14'b0_0_00_00_00_0_1_0_0_0_0;
            ST_BR:   return 14'b0_0_10_01_10_0_0_0_1_0_0;
            ST_UNK:  return 14'b0_0_00_00_00_0_0_0_0_0_1;
            default: return 14'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] outs;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_state(input logic [3:0] s);
        exp_t e;
        e.st   = s;
        e.outs = model_out(s);
        sb_q.push_back(e);
    endtask

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got state %0d", tag, State);
        end else begin
            e = sb_q.pop_front();
            check({tag, "/state"}, 32'(State), 32'(e.st));
            check({tag, "/outs"},  32'(w_outs), 32'(e.outs));
        end
    endtask

    typedef logic [5:0][3:0] seq_t;

    function automatic seq_t mk(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4, input logic [3:0] s5);
        seq_t r;
        r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3; r[4] = s4; r[5] = s5;
        return r;
    endfunction

    // Called at a falling edge with the DUT in seq[0]; leaves it at the falling
    // edge after seq[len-1]. Op/Funct are only meaningful in DECODE/MEMADR, so
    // every other cycle is driven with junk to prove it is ignored.
    task automatic run_seq(input string tag, input logic [1:0] op, input logic [5:0] funct,
                           input seq_t seq, input int len);
        for (int i = 0; i < len; i++) expect_state(seq[i]);
        for (int i = 0; i < len; i++) begin
            compare_next($sformatf("%s[%0d]", tag, i));
            if (seq[i] == ST_D || seq[i] == ST_MA) begin
                Op    = op;
                Funct = funct;
            end else begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        int         len;
        seq_t       seq;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int err0;

        vecs[0] = '{"LDR",     2'b01, 6'b011001, 5, mk(ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_F)};
        vecs[1] = '{"STR",     2'b01, 6'b011000, 4, mk(ST_F, ST_D, ST_MA, ST_MW, ST_F, ST_F)};
        vecs[2] = '{"ADDI",    2'b00, 6'b101000, 4, mk(ST_F, ST_D, ST_EI, ST_AW, ST_F, ST_F)};
        vecs[3] = '{"ADDR",    2'b00, 6'b001000, 4, mk(ST_F, ST_D, ST_ER, ST_AW, ST_F, ST_F)};
        vecs[4] = '{"B",       2'b10, 6'b000000, 3, mk(ST_F, ST_D, ST_BR, ST_F, ST_F, ST_F)};
        vecs[5] = '{"LDR_alt", 2'b01, 6'b100001, 5, mk(ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_F)};
        vecs[6] = '{"STR_alt", 2'b01, 6'b111110, 4, mk(ST_F, ST_D, ST_MA, ST_MW, ST_F, ST_F)};
        vecs[7] = '{"DP_reg",  2'b00, 6'b011111, 4, mk(ST_F, ST_D, ST_ER, ST_AW, ST_F, ST_F)};
        vecs[8] = '{"B_alt",   2'b10, 6'b111111, 3, mk(ST_F, ST_D, ST_BR, ST_F, ST_F, ST_F)};

        // Reset held for two cycles, then first edge moves to DECODE.
        #1 reset = 1'b0;
        err0 = errors;
        repeat (2) begin
            @(negedge clk);
            expect_state(ST_F);
            compare_next("reset_hold");
        end
        reset = 1'b1;
        @(negedge clk);
        expect_state(ST_D);
        compare_next("reset_release");
        $display("txn reset_sequence errors=%0d", errors - err0);

        // Asynchronous reset between edges returns to FETCH immediately.
        err0 = errors;
        #2 reset = 1'b0;
        #1;
        expect_state(ST_F);
        compare_next("async_rst_decode");
        @(negedge clk);
        reset = 1'b1;
        $display("txn async_reset_from_decode errors=%0d", errors - err0);

        for (int v = 0; v < 9; v++) begin
            err0 = errors;
            run_seq(vecs[v].name, vecs[v].op, vecs[v].funct, vecs[v].seq, vecs[v].len);
            $display("txn %s op=%b funct=%b cycles=%0d errors=%0d",
                     vecs[v].name, vecs[v].op, vecs[v].funct, vecs[v].len, errors - err0);
        end

        // Store interrupted in MEMWR: MemW must drop before the next edge.
        err0 = errors;
        run_seq("STR_rst", 2'b01, 6'b011000, mk(ST_F, ST_D, ST_MA, ST_F, ST_F, ST_F), 3);
        expect_state(ST_MW);
        compare_next("STR_rst_memwr");
        #2 reset = 1'b0;
        #1;
        check("STR_rst_memw_drop", 32'(MemW), 32'd0);
        expect_state(ST_F);
        compare_next("STR_rst_fetch");
        @(negedge clk);
        reset = 1'b1;
        $display("txn STR_async_reset errors=%0d", errors - err0);

        // Undefined op: UNKNOWN is absorbing for ten cycles, reset exits it.
        err0 = errors;
        run_seq("UNDEF", 2'b11, 6'b000000, mk(ST_F, ST_D, ST_F, ST_F, ST_F, ST_F), 2);
        for (int i = 0; i < 10; i++) begin
            expect_state(ST_UNK);
            compare_next($sformatf("UNDEF_hold[%0d]", i));
            Op    = 2'($urandom);
            Funct = 6'($urandom);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        expect_state(ST_F);
        compare_next("UNDEF_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_state(ST_D);
        compare_next("UNDEF_after_rst");
        $display("txn UNDEF_absorb errors=%0d", errors - err0);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
